// File: rtl/boreal_frame_asm8.sv
// Receive-side frame assembler: checks strict 0..7 channel order on the tagged ADC
// stream and packs each complete sweep into one 8-lane frame behind a valid/ready port.
module boreal_frame_asm8 #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [2:0]        s_ch,
  input  logic [DW-1:0]     s_data,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [8*DW-1:0]   f_data,
  output logic              seq_err,
  output logic              ovf,
  output logic              locked,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // state | meaning
  // HUNT  | waiting for a ch0 sample to start a sweep
  // FILL  | collecting lanes in order, exp_q is the next expected channel
  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [7*DW-1:0]  lane_q, lane_d;
  logic             f_valid_q, f_valid_d;
  logic [8*DW-1:0]  f_data_q, f_data_d;
  logic             seq_err_q, ovf_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             mismatch, complete, handshake, load, drop;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    lane_d   = lane_q;
    mismatch = 1'b0;
    complete = 1'b0;
    if (s_valid) begin
      if (state_q == ST_HUNT) begin
        if (s_ch == 3'd0) begin
          lane_d[DW-1:0] = s_data;
          exp_d          = 3'd1;
          state_d        = ST_FILL;
        end
      end else if (s_ch == exp_q) begin
        // lane 7 never goes to the buffer; it is taken straight from s_data
        exp_d = exp_q + 3'd1;
        if (exp_q == 3'd7) complete = 1'b1;
        else lane_d[int'(exp_q)*DW +: DW] = s_data;
      end else begin
        mismatch = 1'b1;
        if (s_ch == 3'd0) begin
          lane_d[DW-1:0] = s_data;
          exp_d          = 3'd1;
        end else begin
          state_d = ST_HUNT;
          exp_d   = 3'd0;
        end
      end
    end
  end

  assign handshake = f_valid_q & f_ready;
  assign load      = complete & (~f_valid_q | f_ready);
  assign drop      = complete & f_valid_q & ~f_ready;

  always_comb begin
    f_valid_d = load | (f_valid_q & ~f_ready);
    f_data_d  = load ? {s_data, lane_q} : f_data_q;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (handshake && (frame_cnt_q != {CNT_W{1'b1}}))
      frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    err_inc   = {1'b0, mismatch} + {1'b0, drop};
    err_sum   = {1'b0, err_cnt_q} + {{(CNT_W-1){1'b0}}, err_inc};
    err_cnt_d = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      exp_q       <= 3'd0;
      lane_q      <= '0;
      f_valid_q   <= 1'b0;
      f_data_q    <= '0;
      seq_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      lane_q      <= lane_d;
      f_valid_q   <= f_valid_d;
      f_data_q    <= f_data_d;
      seq_err_q   <= mismatch;
      ovf_q       <= drop;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign f_valid   = f_valid_q;
  assign f_data    = f_data_q;
  assign seq_err   = seq_err_q;
  assign ovf       = ovf_q;
  assign locked    = (state_q == ST_FILL);
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_boreal_frame_asm8.sv
// Bench for boreal_frame_asm8: directed scenarios plus a random stream, all outputs
// compared every cycle against a sweep-level behavioural model.
module tb_boreal_frame_asm8;
  localparam int DW    = 16;
  localparam int CNT_W = 4;
  localparam int FW    = 8 * DW;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic [2:0]       s_ch = 3'd0;
  logic [DW-1:0]    s_data = '0;
  logic             f_ready = 1'b0;
  logic             f_valid;
  logic [FW-1:0]    f_data;
  logic             seq_err, ovf, locked;
  logic [CNT_W-1:0] frame_cnt, err_cnt;

  boreal_frame_asm8 #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .seq_err(seq_err),
    .ovf(ovf), .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_se = 0;
  int n_ovf = 0;

  // model: which lanes have been collected in the current run, and the held frame
  bit            m_lock = 0;
  int            m_exp = 0;
  logic [DW-1:0] m_lanes [8];
  bit            m_fv = 0;
  logic [FW-1:0] m_fd = '0;
  bit            m_se = 0, m_ovf = 0;
  int            m_fc = 0, m_ec = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_exp = 0; m_fv = 0; m_fd = '0; m_se = 0; m_ovf = 0; m_fc = 0; m_ec = 0;
    for (int k = 0; k < 8; k++) m_lanes[k] = '0;
  endtask

  task automatic model_step();
    bit hs, done;
    int se, ov;
    logic [FW-1:0] fr;
    hs = m_fv && f_ready; done = 0; se = 0; ov = 0; fr = '0;
    if (s_valid) begin
      if (!m_lock) begin
        if (s_ch == 3'd0) begin m_lanes[0] = s_data; m_exp = 1; m_lock = 1; end
      end else if (int'(s_ch) == m_exp) begin
        m_lanes[m_exp] = s_data;
        if (m_exp == 7) begin
          done = 1;
          for (int k = 0; k < 8; k++) fr[k*DW +: DW] = m_lanes[k];
          m_exp = 0;
        end else m_exp++;
      end else begin
        se = 1;
        if (s_ch == 3'd0) begin m_lanes[0] = s_data; m_exp = 1; end
        else begin m_lock = 0; m_exp = 0; end
      end
    end
    if (hs) m_fc = (m_fc + 1 > CMAX) ? CMAX : m_fc + 1;
    if (done && (!m_fv || f_ready)) begin
      m_fd = fr; m_fv = 1;
    end else begin
      if (done) ov = 1;
      if (hs) m_fv = 0;
    end
    m_se = se[0]; m_ovf = ov[0];
    m_ec = (m_ec + se + ov > CMAX) ? CMAX : m_ec + se + ov;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("f_valid", FW'(f_valid), FW'(m_fv));
    chk("f_data", f_data, m_fd);
    chk("seq_err", FW'(seq_err), FW'(m_se));
    chk("ovf", FW'(ovf), FW'(m_ovf));
    chk("locked", FW'(locked), FW'(m_lock));
    chk("frame_cnt", FW'(frame_cnt), FW'(m_fc));
    chk("err_cnt", FW'(err_cnt), FW'(m_ec));
    if (!rst_n) begin n_se = 0; n_ovf = 0; end
    else begin
      if (seq_err) n_se++;
      if (ovf) n_ovf++;
    end
  end

  function automatic logic [DW-1:0] dat(input int base, input int ch);
    return DW'(base + 'h11 * ch);
  endfunction

  function automatic logic [FW-1:0] frame_of(input int base);
    logic [FW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*DW +: DW] = dat(base, k);
    return r;
  endfunction

  task automatic cyc(input bit v, input int ch, input logic [DW-1:0] d, input bit rdy);
    @(negedge clk);
    s_valid = v; s_ch = 3'(ch); s_data = d; f_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(0, 0, '0, rdy);
  endtask

  task automatic sweep(input int first, input int last, input int base, input bit rdy);
    for (int c = first; c <= last; c++) cyc(1, c, dat(base, c), rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0; s_valid = 1'b0; f_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int p;
    bit v, rdy;
    int ch;

    // 1: two clean sweeps with downstream always ready
    do_reset();
    sweep(0, 7, 'h100, 1);
    chk("t1_fv_before", FW'(f_valid), FW'(0));
    idle(1, 1);
    chk("t1_fv_after_ch7", FW'(f_valid), FW'(1));
    chk("t1_frame1", f_data, frame_of('h100));
    sweep(0, 7, 'h100, 1);
    idle(3, 1);
    chk("t1_frame_cnt", FW'(frame_cnt), FW'(2));
    chk("t1_no_seq_err", FW'(n_se), FW'(0));
    chk("t1_lane7", FW'(f_data[7*DW +: DW]), FW'(16'h177));

    // 2: stream starts mid-sweep
    do_reset();
    sweep(3, 7, 'h200, 1);
    cyc(1, 0, dat('h300, 0), 1);
    chk("t2_locked_pre", FW'(locked), FW'(0));
    cyc(1, 1, dat('h300, 1), 1);
    chk("t2_locked_post", FW'(locked), FW'(1));
    sweep(2, 7, 'h300, 1);
    idle(3, 1);
    chk("t2_frame_cnt", FW'(frame_cnt), FW'(1));
    chk("t2_no_seq_err", FW'(n_se), FW'(0));
    chk("t2_frame", f_data, frame_of('h300));

    // 3: skipped channel, then mid-run ch0 resync
    do_reset();
    sweep(0, 2, 'h400, 1);
    cyc(1, 4, dat('h400, 4), 1);
    idle(1, 1);
    chk("t3_seq_err_pulse", FW'(seq_err), FW'(1));
    chk("t3_hunt", FW'(locked), FW'(0));
    idle(1, 1);
    chk("t3_err_cnt1", FW'(err_cnt), FW'(1));
    cyc(1, 5, dat('h400, 5), 1);
    sweep(0, 2, 'h500, 1);
    sweep(0, 7, 'h500, 1);
    idle(3, 1);
    chk("t3_err_cnt2", FW'(err_cnt), FW'(2));
    chk("t3_n_seq_err", FW'(n_se), FW'(2));
    chk("t3_frame_cnt", FW'(frame_cnt), FW'(1));
    chk("t3_frame", f_data, frame_of('h500));

    // 4: downstream stalled across three sweeps
    do_reset();
    sweep(0, 7, 'h600, 0);
    sweep(0, 7, 'h700, 0);
    sweep(0, 7, 'h800, 0);
    idle(2, 0);
    chk("t4_fv_held", FW'(f_valid), FW'(1));
    chk("t4_frame_held", f_data, frame_of('h600));
    chk("t4_n_ovf", FW'(n_ovf), FW'(2));
    chk("t4_err_cnt", FW'(err_cnt), FW'(2));
    chk("t4_frame_cnt0", FW'(frame_cnt), FW'(0));
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("t4_frame_cnt1", FW'(frame_cnt), FW'(1));
    chk("t4_fv_drop", FW'(f_valid), FW'(0));
    chk("t4_data_kept", f_data, frame_of('h600));

    // 5: consume and reload in the same cycle
    do_reset();
    sweep(0, 7, 'h900, 0);
    idle(1, 0);
    sweep(0, 6, 'hA00, 0);
    cyc(1, 7, dat('hA00, 7), 1);
    cyc(0, 0, '0, 0);
    chk("t5_fv_stays", FW'(f_valid), FW'(1));
    chk("t5_new_frame", f_data, frame_of('hA00));
    chk("t5_frame_cnt", FW'(frame_cnt), FW'(1));
    idle(2, 0);
    chk("t5_no_ovf", FW'(n_ovf), FW'(0));

    // 6: asynchronous reset mid-frame
    do_reset();
    sweep(0, 4, 'hB00, 0);
    @(posedge clk);
    #3 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    chk("t6_rst_fv", FW'(f_valid), FW'(0));
    chk("t6_rst_fd", f_data, FW'(0));
    chk("t6_rst_lock", FW'(locked), FW'(0));
    chk("t6_rst_flags", FW'({seq_err, ovf}), FW'(0));
    chk("t6_rst_cnts", FW'({frame_cnt, err_cnt}), FW'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    sweep(5, 7, 'hC00, 0);
    idle(2, 0);
    chk("t6_no_frame", FW'(f_valid), FW'(0));
    sweep(0, 7, 'hD00, 0);
    idle(1, 0);
    chk("t6_fresh_frame", f_data, frame_of('hD00));
    chk("t6_fv", FW'(f_valid), FW'(1));

    // random stream: mostly in-order channels with occasional jumps
    do_reset();
    p = 0;
    repeat (3000) begin
      v   = ($urandom % 10) < 7;
      ch  = (($urandom % 12) == 0) ? int'($urandom % 8) : p;
      rdy = ($urandom % 10) < 6;
      if (v) p = (ch + 1) % 8;
      cyc(v, ch, DW'($urandom), rdy);
    end
    idle(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
